// File: rtl/iter_divider.sv
// Multicycle signed divider: restoring shift-subtract, one quotient bit per clock.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
module iter_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // |A| shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Magnitudes wrap, so |MIN_NEG| stays MIN_NEG and is correct as unsigned.
    always_comb begin
        abs_a   = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
        abs_b   = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dsr_q};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (ctrl_DIV) begin
                    dvd_d     = abs_a;
                    dsr_d     = abs_b;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    neg_rem_d = data_operandA[WIDTH-1];
                    ovf_d     = (data_operandA == MIN_NEG) && (data_operandB == '1);
                    if (data_operandB == '0) begin
                        result_d    = '0;
                        remainder_d = data_operandA;
                        exc_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_ITER;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                // A borrow out of the WIDTH+1-bit subtract means the trial went negative.
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d    = neg_quo_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
                remainder_d = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
                exc_d       = ovf_q;
                state_d     = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they align with it.
    always_comb begin
        busy_d = (state_d == S_ITER) || (state_d == S_FIX);
        rdy_d  = (state_d == S_DONE);
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: driver queues expected results with
// their RDY cycle, a negedge monitor pops and compares on every RDY pulse.
module tb_iter_divider;

    logic        clock;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every RDY pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n) begin
            if (busy) busy_cnt++;
            if (data_resultRDY) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rdy: got RDY at cycle %0d expected none", cyc);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    chk("result", data_result, x.q);
                    chk("remainder", data_remainder, x.r);
                    chk("exception", 32'(data_exception), 32'(x.e));
                    chk("rdy_cycle", 32'(cyc), 32'(x.cyc));
                end
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                         input logic [31:0] r, input logic e, input int lat);
        exp_t x;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        x.q = q; x.r = r; x.e = e; x.cyc = cyc + 1 + lat;
        sb.push_back(x);
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        chk("drain_outstanding", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clock);
    endtask

    initial begin
        exp_t x;
        reset_n       = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        chk("rst_result", data_result, 32'd0);
        chk("rst_remainder", data_remainder, 32'd0);
        chk("rst_exception", 32'(data_exception), 32'd0);
        chk("rst_rdy", 32'(data_resultRDY), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        busy_cnt = 0;
        drive(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        drain();
        chk("busy_cycles", 32'(busy_cnt), 32'd33);

        drive(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
        drain();
        drive(32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
        drain();

        busy_cnt = 0;
        drive(32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 0);
        drain();
        chk("div0_busy_cycles", 32'(busy_cnt), 32'd0);

        drive(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 33);
        drain();
        drive(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33);
        drain();
        drive(32'h8000_0000, 32'd7, 32'hEDB6_DB6E, 32'hFFFF_FFFE, 1'b0, 33);
        drain();
        drive(32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 33);
        drain();

        // Start request mid-division must be ignored.
        drive(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33);
        repeat (9) @(negedge clock);
        data_operandA = 32'd7;
        data_operandB = 32'd2;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        drain();

        // New start in the RDY cycle is accepted with no bubble.
        drive(32'd40, 32'd8, 32'd5, 32'd0, 1'b0, 33);
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (data_resultRDY) break;
        end
        data_operandA = 32'hFFFF_FFF9;
        data_operandB = 32'd2;
        ctrl_DIV      = 1'b1;
        x.q = 32'hFFFF_FFFD; x.r = 32'hFFFF_FFFF; x.e = 1'b0; x.cyc = cyc + 1 + 33;
        sb.push_back(x);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        drain();

        // Asynchronous reset mid-ITER aborts the division.
        drive(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_result", data_result, 32'd0);
        chk("arst_remainder", data_remainder, 32'd0);
        chk("arst_exception", 32'(data_exception), 32'd0);
        chk("arst_rdy", 32'(data_resultRDY), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        sb.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        drive(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
